// File: rtl/beamformer_pkg.sv
// Shared parameters and FSM state encoding for the beamformer frame scheduler.
// Defaults describe the 8-bit, 2-channel, 16-clock-slot configuration.
package beamformer_pkg;

  localparam int NUMBER_OF_BITS = 8;
  localparam int BUFFER_SIZE    = 8;
  localparam int NUM_CHANNELS   = 2;
  localparam int SLOT_BITS      = 16;
  localparam int FRAME_BITS     = 2 * SLOT_BITS;
  localparam int IDX_W          = $clog2(BUFFER_SIZE);
  localparam int CHAN_W         = 3;

  typedef enum logic [1:0] {
    IDLE,
    CLR,
    READ,
    LOAD
  } sched_state_t;

  // Requested delays beyond the buffer depth saturate at the deepest tap.
  function automatic int clamp_delay(input int delay, input int max_delay);
    return (delay > max_delay) ? max_delay : delay;
  endfunction

endpackage

// File: rtl/beam_frame_scheduler_if.sv
// Frame strobes, buffer-read controls and serial config pins of the scheduler.
// master = scheduler side, slave = datapath / config source side.
interface beam_frame_scheduler_if #(
  parameter int IDX_W = beamformer_pkg::IDX_W
);
  logic             ena;
  logic             ws;
  logic             cap_left;
  logic             cap_right;
  logic             buf_shift;
  logic             cfg_sclk;
  logic             cfg_sdata;
  logic [2:0]       cfg_sel;
  logic             rd_en;
  logic [2:0]       rd_chan;
  logic [IDX_W-1:0] rd_index;
  logic             acc_clr;
  logic             out_load;
  logic             cfg_err;

  modport master (
    input  ena, cfg_sclk, cfg_sdata, cfg_sel,
    output ws, cap_left, cap_right, buf_shift,
    output rd_en, rd_chan, rd_index, acc_clr, out_load, cfg_err
  );

  modport slave (
    output ena, cfg_sclk, cfg_sdata, cfg_sel,
    input  ws, cap_left, cap_right, buf_shift,
    input  rd_en, rd_chan, rd_index, acc_clr, out_load, cfg_err
  );
endinterface

// File: rtl/cfg_serial_sync.sv
// Brings the asynchronous serial config clock into clk and flags its rising edges.
// Data and select ride a pipeline of equal depth so they line up with the edge flag.
module cfg_serial_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_sclk,
  input  logic       cfg_sdata,
  input  logic [2:0] cfg_sel,
  output logic       sclk_rise,
  output logic       sdata_sync,
  output logic [2:0] sel_sync
);
  logic [2:0] sclk_reg;
  logic [1:0] sdata_reg;
  logic [2:0] sel_reg [2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_reg   <= '0;
      sdata_reg  <= '0;
      sel_reg[0] <= '0;
      sel_reg[1] <= '0;
    end else begin
      sclk_reg   <= {sclk_reg[1:0], cfg_sclk};
      sdata_reg  <= {sdata_reg[0], cfg_sdata};
      sel_reg[0] <= cfg_sel;
      sel_reg[1] <= sel_reg[0];
    end
  end

  // Stage 1 is the first metastability-safe copy; stage 2 only serves edge detection.
  assign sclk_rise  = sclk_reg[1] & ~sclk_reg[2];
  assign sdata_sync = sdata_reg[1];
  assign sel_sync   = sel_reg[1];

endmodule

// File: rtl/beam_frame_scheduler.sv
// I2S frame timing plus the once-per-frame delay-read / accumulate / load sequence.
// Per-channel delays are shifted in serially and take effect only in the CLR cycle.
module beam_frame_scheduler #(
  parameter int NUMBER_OF_BITS = beamformer_pkg::NUMBER_OF_BITS,
  parameter int BUFFER_SIZE    = beamformer_pkg::BUFFER_SIZE,
  parameter int NUM_CHANNELS   = beamformer_pkg::NUM_CHANNELS,
  parameter int SLOT_BITS      = beamformer_pkg::SLOT_BITS
) (
  input logic                   clk,
  input logic                   rst_n,
  beam_frame_scheduler_if.master bus
);
  import beamformer_pkg::*;

  localparam int FRAME_LEN = 2 * SLOT_BITS;
  localparam int DELAY_W   = $clog2(BUFFER_SIZE);
  localparam int CNT_W     = $clog2(FRAME_LEN);

  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] SLOT_CNT  = CNT_W'(SLOT_BITS);
  localparam logic [CNT_W-1:0] CAP_L_CNT = CNT_W'(NUMBER_OF_BITS + 1);
  localparam logic [CNT_W-1:0] CAP_R_CNT = CNT_W'(SLOT_BITS + NUMBER_OF_BITS + 1);
  localparam logic [2:0]       LAST_CHAN = 3'(NUM_CHANNELS - 1);

  if ((NUM_CHANNELS + 2 > SLOT_BITS) || (NUMBER_OF_BITS + 2 > SLOT_BITS) ||
      (NUM_CHANNELS < 1) || (NUM_CHANNELS > 8) || (BUFFER_SIZE < 4)) begin : g_bad_params
    $error("beam_frame_scheduler: parameters do not fit the frame timing");
  end

  logic [CNT_W-1:0] frame_cnt_reg, frame_cnt_next;
  logic             ws_reg;
  logic             frame_start;

  sched_state_t     state_reg, state_next;
  logic [2:0]       chan_reg, chan_next;
  logic             acc_clr, rd_en, out_load, load_active;

  logic             cfg_rise, cfg_bit;
  logic [2:0]       cfg_sel_s;
  logic             cfg_err_reg;

  logic [NUM_CHANNELS-1:0][DELAY_W-1:0] active_bus;
  logic [DELAY_W-1:0]                   rd_index_mux;

  // ---------------- frame timing ----------------
  always_comb begin
    frame_cnt_next = frame_cnt_reg;
    if (bus.ena) begin
      frame_cnt_next = (frame_cnt_reg == LAST_CNT) ? '0 : frame_cnt_reg + 1'b1;
    end
  end

  // ws is registered from the next count so it always matches the current slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_reg <= '0;
      ws_reg        <= 1'b0;
    end else begin
      frame_cnt_reg <= frame_cnt_next;
      ws_reg        <= (frame_cnt_next >= SLOT_CNT);
    end
  end

  assign frame_start = bus.ena && (frame_cnt_reg == LAST_CNT);

  // ---------------- read sequencer ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      chan_reg  <= '0;
    end else begin
      state_reg <= state_next;
      chan_reg  <= chan_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    chan_next   = chan_reg;
    acc_clr     = 1'b0;
    rd_en       = 1'b0;
    out_load    = 1'b0;
    load_active = 1'b0;
    case (state_reg)
      IDLE: begin
        if (frame_start) state_next = CLR;
      end
      CLR: begin
        acc_clr     = 1'b1;
        load_active = 1'b1;
        chan_next   = '0;
        state_next  = READ;
      end
      READ: begin
        rd_en = 1'b1;
        if (chan_reg == LAST_CHAN) begin
          state_next = LOAD;
        end else begin
          chan_next = chan_reg + 3'd1;
        end
      end
      LOAD: begin
        out_load   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------- serial delay configuration ----------------
  cfg_serial_sync u_cfg_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_sclk   (bus.cfg_sclk),
    .cfg_sdata  (bus.cfg_sdata),
    .cfg_sel    (bus.cfg_sel),
    .sclk_rise  (cfg_rise),
    .sdata_sync (cfg_bit),
    .sel_sync   (cfg_sel_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err_reg <= 1'b0;
    end else if (cfg_rise && ({1'b0, cfg_sel_s} >= 4'(NUM_CHANNELS))) begin
      cfg_err_reg <= 1'b1;
    end
  end

  // A shift landing on the CLR edge is not seen by active until the next frame.
  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
    logic [DELAY_W-1:0] shadow_reg;
    logic [DELAY_W-1:0] active_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        shadow_reg <= '0;
        active_reg <= '0;
      end else begin
        if (load_active) begin
          active_reg <= DELAY_W'(clamp_delay(int'(shadow_reg), BUFFER_SIZE - 1));
        end
        if (cfg_rise && (cfg_sel_s == 3'(gi))) begin
          shadow_reg <= {shadow_reg[DELAY_W-2:0], cfg_bit};
        end
      end
    end

    assign active_bus[gi] = active_reg;
  end

  always_comb begin
    rd_index_mux = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (chan_reg == 3'(c)) rd_index_mux = active_bus[c];
    end
  end

  // ---------------- outputs ----------------
  assign bus.ws        = ws_reg;
  assign bus.cap_left  = bus.ena && (frame_cnt_reg == CAP_L_CNT);
  assign bus.cap_right = bus.ena && (frame_cnt_reg == CAP_R_CNT);
  assign bus.buf_shift = frame_start;
  assign bus.acc_clr   = acc_clr;
  assign bus.rd_en     = rd_en;
  assign bus.rd_chan   = rd_en ? chan_reg : 3'd0;
  assign bus.rd_index  = rd_en ? rd_index_mux : '0;
  assign bus.out_load  = out_load;
  assign bus.cfg_err   = cfg_err_reg;

endmodule

// File: tb/tb_beam_frame_scheduler.sv
// Directed bench: an 8-deep and a 6-deep scheduler share stimulus; a cycle model
// of frame timing, sequence and delays sets every expected output.
module tb_beam_frame_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  beam_frame_scheduler_if #(.IDX_W(3)) bus ();
  beam_frame_scheduler_if #(.IDX_W(3)) bus6 ();

  beam_frame_scheduler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  beam_frame_scheduler #(.BUFFER_SIZE(6)) dut6 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus6)
  );

  int errors = 0;
  int checks = 0;

  // model state
  int cnt, ph;
  int sh[2], act[2], act6[2];
  bit err_m, ena_m, pend;
  int pend_sel, pend_bit;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cnt=%0d ph=%0d t=%0t)", tag, actual, expected, cnt, ph, $time);
    end
  endtask

  function automatic int clampd(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [13:0] pack8();
    return {bus.ws, bus.cap_left, bus.cap_right, bus.buf_shift, bus.acc_clr, bus.rd_en,
            bus.rd_chan, bus.rd_index, bus.out_load, bus.cfg_err};
  endfunction

  function automatic logic [13:0] model8();
    logic       ws_e, capl, capr, bs, acc, rden, load;
    logic [2:0] chan, idx;
    ws_e = (cnt >= 16);
    capl = ena_m && (cnt == 9);
    capr = ena_m && (cnt == 25);
    bs   = ena_m && (cnt == 31);
    acc  = (ph == 0);
    rden = (ph == 1) || (ph == 2);
    chan = (ph == 2) ? 3'd1 : 3'd0;
    idx  = (ph == 1) ? 3'(act[0]) : (ph == 2) ? 3'(act[1]) : 3'd0;
    load = (ph == 3);
    return {ws_e, capl, capr, bs, acc, rden, chan, idx, load, err_m};
  endfunction

  function automatic logic [3:0] model6();
    logic [2:0] idx;
    idx = (ph == 1) ? 3'(act6[0]) : (ph == 2) ? 3'(act6[1]) : 3'd0;
    return {err_m, idx};
  endfunction

  task automatic set_ena(input bit v);
    ena_m    = v;
    bus.ena  = v;
    bus6.ena = v;
  endtask

  task automatic set_cfg(input bit sclk, input bit d, input logic [2:0] sel);
    bus.cfg_sclk   = sclk;
    bus.cfg_sdata  = d;
    bus.cfg_sel    = sel;
    bus6.cfg_sclk  = sclk;
    bus6.cfg_sdata = d;
    bus6.cfg_sel   = sel;
  endtask

  task automatic model_reset();
    cnt = 0; ph = -1; err_m = 1'b0; pend = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sh[i] = 0; act[i] = 0; act6[i] = 0;
    end
  endtask

  // One clock: advance the model across the edge, then compare both DUTs.
  task automatic tick();
    @(posedge clk);
    if (ph == 0) begin
      for (int i = 0; i < 2; i++) begin
        act[i]  = clampd(sh[i], 7);
        act6[i] = clampd(sh[i], 5);
      end
    end
    if (pend) begin
      if (pend_sel < 2) sh[pend_sel] = ((sh[pend_sel] << 1) | pend_bit) & 7;
      else err_m = 1'b1;
      pend = 1'b0;
    end
    if (ph >= 0) ph = (ph == 3) ? -1 : ph + 1;
    else if (ena_m && cnt == 31) ph = 0;
    if (ena_m) cnt = (cnt == 31) ? 0 : cnt + 1;
    #1;
    check("outputs", 32'(pack8()), 32'(model8()));
    check("dut6_err_idx", 32'({bus6.cfg_err, bus6.rd_index}), 32'(model6()));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Config bit takes effect on the third clock edge after the sclk rise.
  task automatic cfg_bit(input int sel, input int b);
    set_cfg(1'b1, 1'(b), 3'(sel));
    tick();
    tick();
    pend = 1'b1; pend_sel = sel; pend_bit = b;
    tick();
    set_cfg(1'b0, 1'(b), 3'(sel));
    run(3);
  endtask

  task automatic wait_until(input int c, input int p);
    int n;
    n = 0;
    while (!(cnt == c && (p == -2 || ph == p)) && n < 80) begin
      tick();
      n++;
    end
    check("wait_bound", 32'(n < 80), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("reset_outputs", 32'({pack8(), bus6.cfg_err, bus6.rd_index}), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    set_ena(1'b0);
    set_cfg(1'b0, 1'b0, 3'd0);
    model_reset();
    @(posedge clk);
    #1;
    do_reset();
    set_ena(1'b1);

    // free run with zero delays: two frames plus margin
    run(70);

    // delay 3'b101 on channel 1
    cfg_bit(1, 1); cfg_bit(1, 0); cfg_bit(1, 1);
    run(70);

    // delay 3'b111 on channel 0: 7 in the 8-deep unit, clamped to 5 in the 6-deep unit
    cfg_bit(0, 1); cfg_bit(0, 1); cfg_bit(0, 1);
    run(40);

    // out-of-range select: sticky error, shadows untouched
    cfg_bit(3, 1);
    run(40);

    // shift edge lands on the CLR edge: old delay this frame, new one next frame
    wait_until(30, -2);
    cfg_bit(1, 0);
    run(70);

    // freeze mid-sequence: sequence completes, timing holds, no new frame
    wait_until(2, 2);
    set_ena(1'b0);
    run(40);
    set_ena(1'b1);
    run(40);

    // reset in the middle of READ, then a clean restart
    wait_until(1, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_read", 32'({pack8(), bus6.cfg_err, bus6.rd_index}), 32'd0);
    do_reset();
    run(80);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
